// File: rtl/mxint8_block_decoder.sv
// mxint8_block_decoder: buffers one MXINT8 block and streams it out as float32, one per handshake.
// Define MXINT8_DECODE_SUBNORMAL_EN to emit exact subnormals instead of flushing them to signed zero.
module mxint8_block_decoder #(
    parameter int BLOCK_SIZE = 32,
    parameter int IDX_W      = $clog2(BLOCK_SIZE)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [7:0]              i_scale,
    input  logic [8*BLOCK_SIZE-1:0] i_mxint8_elements,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [31:0]             o_float32,
    output logic [IDX_W-1:0]        o_index,
    output logic                    o_last
);
    typedef enum logic {IDLE, STREAM} state_t;
    state_t                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [7:0]              r_scale;
    logic [8*BLOCK_SIZE-1:0] r_buf;
    logic                    w_last;
    logic                    w_hs;
    logic                    w_accept;
    logic [7:0]              w_e;
    logic [7:0]              w_mag;
    logic [2:0]              w_p;
    logic signed [9:0]       w_eb;
    logic [22:0]             w_mant;
    logic [31:0]             w_sub;
    assign o_valid  = r_state == STREAM;
    assign o_index  = r_idx;
    assign w_last   = o_valid && r_idx == IDX_W'(BLOCK_SIZE - 1);
    assign o_last   = w_last;
    assign w_hs     = o_valid && i_ready;
    assign o_ready  = !i_rst && (r_state == IDLE || (w_hs && w_last));
    assign w_accept = i_valid && o_ready;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_state <= STREAM;
            r_idx   <= '0;
            r_scale <= i_scale;
            r_buf   <= i_mxint8_elements;
        end else if (w_hs) begin
            r_state <= w_last ? IDLE : STREAM;
            r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
        end
    end
    assign w_e   = r_buf[{r_idx, 3'b000} +: 8];
    assign w_mag = w_e[7] ? -w_e : w_e;
    always_comb begin
        w_p = 3'd0;
        for (int k = 0; k < 8; k++)
            if (w_mag[k]) w_p = 3'(k);
    end
    assign w_eb = $signed({2'b00, r_scale}) - 10'sd6 + $signed({7'b0, w_p});
    // Shift the leading one up to bit 23 so bits 22:0 are the left-aligned fraction.
    assign w_mant = 23'(32'(w_mag) << (5'd23 - {2'b00, w_p}));
`ifdef MXINT8_DECODE_SUBNORMAL_EN
    assign w_sub = {w_e[7], 8'h00, 23'(32'(w_mag) << (r_scale[4:0] + 5'd16))};
`else
    assign w_sub = {w_e[7], 31'h0};
`endif
    assign o_float32 = (r_scale == 8'hFF) ? 32'h7FC0_0000 :
                       (w_mag == 8'd0)    ? 32'h0000_0000 :
                       (w_eb >= 10'sd255) ? {w_e[7], 31'h7F7F_FFFF} :
                       (w_eb >= 10'sd1)   ? {w_e[7], w_eb[7:0], w_mant} : w_sub;
endmodule

// File: tb/tb_mxint8_block_decoder.sv
// tb_mxint8_block_decoder: directed vector table plus handshake, backpressure and reset sequences.
module tb_mxint8_block_decoder;
    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_valid = 1'b0;
    logic         i_ready = 1'b0;
    logic [7:0]   i_scale = 8'd0;
    logic [255:0] i_mxint8_elements = '0;
    logic         o_ready;
    logic         o_valid;
    logic         o_last;
    logic [31:0]  o_float32;
    logic [4:0]   o_index;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  s;
        logic [7:0]  e;
        logic [31:0] f;
    } vec_t;
    vec_t tbl[16];

    mxint8_block_decoder dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_scale(i_scale), .i_mxint8_elements(i_mxint8_elements), .o_valid(o_valid),
        .i_ready(i_ready), .o_float32(o_float32), .o_index(o_index), .o_last(o_last)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #2;
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, a, e);
        end
    endtask

    function automatic logic [255:0] fill(input logic [7:0] e);
        return {32{e}};
    endfunction

    task automatic run_block(input logic [7:0] s, input logic [255:0] el, input logic [1023:0] ex);
        i_scale = s;
        i_mxint8_elements = el;
        i_valid = 1'b1;
        i_ready = 1'b1;
        #1;
        chk("accept_ready", {31'b0, o_ready}, 32'd1);
        tick;
        i_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("valid[%0d] s=%h", k, s), {31'b0, o_valid}, 32'd1);
            chk($sformatf("index[%0d] s=%h", k, s), {27'b0, o_index}, 32'(k));
            chk($sformatf("last[%0d] s=%h", k, s), {31'b0, o_last}, {31'b0, k == 31});
            chk($sformatf("float[%0d] s=%h", k, s), o_float32, ex[k*32 +: 32]);
            tick;
        end
        chk("idle_after_block", {31'b0, o_valid}, 32'd0);
    endtask

    initial begin
        logic [255:0]  el;
        logic [1023:0] ex;
        tbl[0]  = '{8'd127, 8'h40, 32'h3F80_0000};
        tbl[1]  = '{8'd127, 8'h80, 32'hC000_0000};
        tbl[2]  = '{8'd127, 8'hC0, 32'hBF80_0000};
        tbl[3]  = '{8'd127, 8'h01, 32'h3C80_0000};
        tbl[4]  = '{8'd127, 8'h00, 32'h0000_0000};
        tbl[5]  = '{8'd127, 8'h7F, 32'h3FFE_0000};
        tbl[6]  = '{8'hFF,  8'h00, 32'h7FC0_0000};
        tbl[7]  = '{8'hFF,  8'h80, 32'h7FC0_0000};
        tbl[8]  = '{8'hFF,  8'h55, 32'h7FC0_0000};
        tbl[9]  = '{8'd254, 8'h80, 32'hFF7F_FFFF};
        tbl[10] = '{8'd253, 8'h80, 32'hFF00_0000};
        tbl[11] = '{8'd254, 8'h7F, 32'h7F7E_0000};
        tbl[12] = '{8'd7,   8'h01, 32'h0080_0000};
`ifdef MXINT8_DECODE_SUBNORMAL_EN
        tbl[13] = '{8'd0,   8'h01, 32'h0001_0000};
        tbl[14] = '{8'd0,   8'hFF, 32'h8001_0000};
        tbl[15] = '{8'd6,   8'h01, 32'h0040_0000};
`else
        tbl[13] = '{8'd0,   8'h01, 32'h0000_0000};
        tbl[14] = '{8'd0,   8'hFF, 32'h8000_0000};
        tbl[15] = '{8'd6,   8'h01, 32'h0000_0000};
`endif
        tick;
        tick;
        chk("rst_ready", {31'b0, o_ready}, 32'd0);
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        i_rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'b0, o_ready}, 32'd1);
        chk("post_rst_valid", {31'b0, o_valid}, 32'd0);
        chk("post_rst_index", {27'b0, o_index}, 32'd0);
        chk("post_rst_last", {31'b0, o_last}, 32'd0);

        for (int v = 0; v < 16; v++)
            run_block(tbl[v].s, fill(tbl[v].e), {32{tbl[v].f}});

        el = fill(8'h40);
        ex = {32{32'h3F80_0000}};
        el[7:0] = 8'h80;   ex[31:0]   = 32'hC000_0000;
        el[15:8] = 8'hC0;  ex[63:32]  = 32'hBF80_0000;
        el[23:16] = 8'h01; ex[95:64]  = 32'h3C80_0000;
        el[31:24] = 8'h00; ex[127:96] = 32'h0000_0000;
        el[39:32] = 8'h7F; ex[159:128] = 32'h3FFE_0000;
        run_block(8'd127, el, ex);

        for (int k = 0; k < 32; k++) el[k*8 +: 8] = 8'(k + 1);
        i_scale = 8'd127;
        i_mxint8_elements = el;
        i_valid = 1'b1;
        i_ready = 1'b0;
        tick;
        i_valid = 1'b0;
        chk("bp_idx0", {27'b0, o_index}, 32'd0);
        chk("bp_f0", o_float32, 32'h3C80_0000);
        tick;
        chk("bp_hold_idx0", {27'b0, o_index}, 32'd0);
        chk("bp_hold_f0", o_float32, 32'h3C80_0000);
        chk("bp_hold_valid", {31'b0, o_valid}, 32'd1);
        i_ready = 1'b1;
        tick;
        chk("bp_idx1", {27'b0, o_index}, 32'd1);
        chk("bp_f1", o_float32, 32'h3D00_0000);
        i_ready = 1'b0;
        tick;
        chk("bp_hold_idx1", {27'b0, o_index}, 32'd1);
        chk("bp_hold_f1", o_float32, 32'h3D00_0000);
        i_ready = 1'b1;
        tick;
        chk("bp_idx2", {27'b0, o_index}, 32'd2);
        chk("bp_f2", o_float32, 32'h3D40_0000);
        i_ready = 1'b0;
        tick;
        chk("bp_hold_idx2", {27'b0, o_index}, 32'd2);
        chk("bp_hold_f2", o_float32, 32'h3D40_0000);
        i_ready = 1'b1;
        for (int c = 0; c < 40 && !o_last; c++) tick;
        chk("bp_reach_last", {31'b0, o_last}, 32'd1);
        chk("bp_f31", o_float32, 32'h3F00_0000);
        tick;
        chk("bp_idle", {31'b0, o_valid}, 32'd0);

        i_scale = 8'd127;
        i_mxint8_elements = fill(8'h40);
        i_valid = 1'b1;
        tick;
        i_valid = 1'b0;
        for (int k = 0; k < 29; k++) tick;
        i_mxint8_elements = fill(8'hC0);
        i_valid = 1'b1;
        #1;
        chk("b2b_ready_mid", {31'b0, o_ready}, 32'd0);
        tick;
        chk("b2b_idx30", {27'b0, o_index}, 32'd30);
        chk("b2b_f30_kept", o_float32, 32'h3F80_0000);
        tick;
        #1;
        chk("b2b_last", {31'b0, o_last}, 32'd1);
        chk("b2b_ready_last", {31'b0, o_ready}, 32'd1);
        tick;
        i_valid = 1'b0;
        chk("b2b_valid", {31'b0, o_valid}, 32'd1);
        chk("b2b_idx0", {27'b0, o_index}, 32'd0);
        chk("b2b_f0", o_float32, 32'hBF80_0000);
        for (int c = 0; c < 40 && !o_last; c++) tick;
        chk("b2b_reach_last", {31'b0, o_last}, 32'd1);
        tick;
        chk("b2b_idle", {31'b0, o_valid}, 32'd0);

        i_mxint8_elements = fill(8'h40);
        i_valid = 1'b1;
        tick;
        i_valid = 1'b0;
        for (int k = 0; k < 10; k++) tick;
        chk("rst_mid_idx10", {27'b0, o_index}, 32'd10);
        i_rst = 1'b1;
        tick;
        chk("rst_mid_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_mid_ready", {31'b0, o_ready}, 32'd0);
        chk("rst_mid_index", {27'b0, o_index}, 32'd0);
        i_rst = 1'b0;
        #1;
        chk("rst_mid_release_ready", {31'b0, o_ready}, 32'd1);
        run_block(8'd127, fill(8'hC0), {32{32'hBF80_0000}});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
